// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, ALU classes,
// FSM state codes and datapath mux selects.
package multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SLTU  = 3'b010;
  localparam logic [2:0] ALU_BEQ   = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_BNE   = 3'b110;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_RTYPE = 3'd0,
    CLS_IMM   = 3'd1,
    CLS_BEQ   = 3'd2,
    CLS_BNE   = 3'd3,
    CLS_LW    = 3'd4,
    CLS_SW    = 3'd5,
    CLS_JUMP  = 3'd6
  } op_class_e;

endpackage

// File: rtl/multicycle_ctrl_op_decode.sv
// Combinational opcode decoder: class, ALU op, ALU B select, extension mode, legality.
// The j opcode is legal only when MULTICYCLE_CTRL_JUMP_EN is defined.
module mc_op_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] op_i,
  output logic [2:0]          class_o,
  output logic [2:0]          alu_op_o,
  output logic [1:0]          alu_src_b_o,
  output logic                extend_zero_o,
  output logic                legal_o
);

  always_comb begin
    class_o       = CLS_RTYPE;
    alu_op_o      = ALU_RTYPE;
    alu_src_b_o   = SRCB_RT;
    extend_zero_o = 1'b0;
    legal_o       = 1'b1;
    case (op_i)
      OPCODE_W'(OP_RTYPE): class_o = CLS_RTYPE;
      OPCODE_W'(OP_ADDI):  begin class_o = CLS_IMM; alu_op_o = ALU_ADD;  alu_src_b_o = SRCB_IMM; end
      OPCODE_W'(OP_SLTIU): begin class_o = CLS_IMM; alu_op_o = ALU_SLTU; alu_src_b_o = SRCB_IMM; end
      OPCODE_W'(OP_LUI):   begin class_o = CLS_IMM; alu_op_o = ALU_LUI;  alu_src_b_o = SRCB_IMM; end
      OPCODE_W'(OP_ORI): begin
        class_o       = CLS_IMM;
        alu_op_o      = ALU_OR;
        alu_src_b_o   = SRCB_IMM;
        extend_zero_o = 1'b1;
      end
      OPCODE_W'(OP_BEQ):   begin class_o = CLS_BEQ; alu_op_o = ALU_BEQ; end
      OPCODE_W'(OP_BNE):   begin class_o = CLS_BNE; alu_op_o = ALU_BNE; end
      OPCODE_W'(OP_LW):    begin class_o = CLS_LW;  alu_op_o = ALU_ADD; alu_src_b_o = SRCB_IMM; end
      OPCODE_W'(OP_SW):    begin class_o = CLS_SW;  alu_op_o = ALU_ADD; alu_src_b_o = SRCB_IMM; end
`ifdef MULTICYCLE_CTRL_JUMP_EN
      OPCODE_W'(OP_J):     class_o = CLS_JUMP;
`endif
      default:             legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory-ready wait/timeout and retire counter.
// Optional jump support is enabled by MULTICYCLE_CTRL_JUMP_EN.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [OPCODE_W-1:0] instr_op_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic                pc_write_cond_o,
  output logic                branch_ne_o,
  output logic [1:0]          pc_src_o,
  output logic                ir_write_o,
  output logic                iord_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                mem_to_reg_o,
  output logic                reg_write_o,
  output logic                reg_dst_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                extend_zero_o,
  output logic                illegal_o,
  output logic                timeout_o,
  output logic [2:0]          state_o,
  output logic [CNT_W-1:0]    instr_cnt_o
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                retire, waiting, expired;
  logic [2:0]          alu_op3;

  logic [OPCODE_W-1:0] dec_op;
  logic [2:0]          dec_class, dec_alu_op;
  logic [1:0]          dec_src_b;
  logic                dec_ez, dec_legal;
  op_class_e           cls;

  // DECODE judges the live opcode; later states work from the latched copy.
  assign dec_op = (state_q == S_DECODE) ? instr_op_i : op_q;
  assign cls    = op_class_e'(dec_class);

  mc_op_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .op_i          (dec_op),
    .class_o       (dec_class),
    .alu_op_o      (dec_alu_op),
    .alu_src_b_o   (dec_src_b),
    .extend_zero_o (dec_ez),
    .legal_o       (dec_legal)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    retire          = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    branch_ne_o     = 1'b0;
    pc_src_o        = PCSRC_ALU;
    ir_write_o      = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_RT;
    alu_op3         = ALU_RTYPE;
    extend_zero_o   = 1'b0;
    illegal_o       = 1'b0;
    timeout_o       = 1'b0;

    waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready_i;
    expired = waiting && (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read_o  = !expired;
        alu_src_b_o = SRCB_FOUR;
        alu_op3     = ALU_ADD;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (expired) begin
          timeout_o = 1'b1;
        end
      end
      S_DECODE: begin
        op_d        = instr_op_i;
        alu_src_b_o = SRCB_IMM_SL2;
        alu_op3     = ALU_ADD;
        if (dec_legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_o = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXEC: begin
        // rs feeds ALU A for every executed operation (compare, address, arithmetic).
        alu_src_a_o   = 1'b1;
        alu_src_b_o   = dec_src_b;
        alu_op3       = dec_alu_op;
        extend_zero_o = dec_ez;
        state_d       = S_FETCH;
        if (dec_legal) begin
          case (cls)
            CLS_RTYPE, CLS_IMM: state_d = S_WB;
            CLS_BEQ, CLS_BNE: begin
              pc_write_cond_o = 1'b1;
              pc_src_o        = PCSRC_ALUOUT;
              branch_ne_o     = (cls == CLS_BNE);
              retire          = 1'b1;
            end
            CLS_LW, CLS_SW: state_d = S_MEM;
`ifdef MULTICYCLE_CTRL_JUMP_EN
            CLS_JUMP: begin
              alu_src_a_o = 1'b0;
              pc_write_o  = 1'b1;
              pc_src_o    = PCSRC_JUMP;
              retire      = 1'b1;
            end
`endif
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEM: begin
        iord_o = 1'b1;
        if ((cls != CLS_LW) && (cls != CLS_SW)) begin
          state_d = S_FETCH;
        end else begin
          mem_read_o  = (cls == CLS_LW) && !expired;
          mem_write_o = (cls == CLS_SW) && !expired;
          if (mem_ready_i) begin
            state_d = (cls == CLS_LW) ? S_WB : S_FETCH;
            retire  = (cls == CLS_SW);
          end else if (expired) begin
            timeout_o = 1'b1;
            state_d   = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = (cls == CLS_RTYPE);
        mem_to_reg_o = (cls == CLS_LW);
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // A timeout in FETCH keeps the state, so it must clear the count explicitly.
    if ((state_d != state_q) || expired) begin
      wait_d = '0;
    end else if (waiting) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end

    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  assign alu_op_o    = ALU_OP_W'(alu_op3);
  assign state_o     = state_q;
  assign instr_cnt_o = cnt_q;

endmodule
